// File: rtl/arb_pkg.sv
// Shared types and constants for the fetch/data memory-port arbiter.
package arb_pkg;

  localparam int unsigned LINE_W       = 128;
  localparam int unsigned BE_W         = LINE_W / 8;
  localparam int unsigned STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational next-grant selector used while the arbiter is idle.
module arb_pick
  import arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       i_fetch_req,
  input  logic       i_data_req,
  input  logic       i_last_d,
  input  logic       i_starve_hit,
  output arb_state_t o_next
);

  always_comb begin
    o_next = IDLE;
    if (i_fetch_req && i_data_req) begin
      if (FIXED_PRIO) o_next = i_starve_hit ? GNT_I : GNT_D;
      else            o_next = i_last_d     ? GNT_I : GNT_D;
    end else if (i_fetch_req) begin
      o_next = GNT_I;
    end else if (i_data_req) begin
      o_next = GNT_D;
    end
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one 128-bit memory port between the fetch and data cache clients.
// Grants are registered and held until the granted transfer completes.
module imem_dmem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 128,
  parameter int unsigned FIXED_PRIO   = 0,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic                    i_rd,
  output logic [DATA_WIDTH-1:0]   i_data,
  output logic                    i_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic                    d_rd,
  input  logic                    d_wr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_waitrequest,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_rd,
  output logic                    mem_wr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_waitrequest
);

  arb_state_t              r_state;
  arb_state_t              w_state_nxt;
  arb_state_t              w_pick;
  logic                    r_last_d;
  logic [STARVE_CNT_W-1:0] r_starve_cnt;

  logic w_i_req;
  logic w_d_req;
  logic w_live;
  logic w_done;
  logic w_starve_hit;

  assign w_i_req      = i_rd;
  assign w_d_req      = d_rd | d_wr;
  assign w_starve_hit = (r_starve_cnt == STARVE_CNT_W'(STARVE_LIMIT));

  // A grant whose owner has dropped its request is not live: no strobe, back to idle.
  assign w_live = ((r_state == GNT_I) && w_i_req) || ((r_state == GNT_D) && w_d_req);
  assign w_done = w_live && !mem_waitrequest;

  arb_pick #(
    .FIXED_PRIO (FIXED_PRIO != 0)
  ) u_pick (
    .i_fetch_req  (w_i_req),
    .i_data_req   (w_d_req),
    .i_last_d     (r_last_d),
    .i_starve_hit (w_starve_hit),
    .o_next       (w_pick)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:         w_state_nxt = w_pick;
      GNT_I, GNT_D: if (!w_live || !mem_waitrequest) w_state_nxt = IDLE;
      default:      w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_d     <= 1'b0;
      r_starve_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_done) r_last_d <= (r_state == GNT_D);
      if (r_state == IDLE && w_pick == GNT_I)
        r_starve_cnt <= '0;
      else if (r_state == IDLE && w_pick == GNT_D && w_i_req && !w_starve_hit)
        r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    mem_be    = '0;
    if (r_state == GNT_I && w_i_req) begin
      mem_addr = i_addr;
      mem_rd   = 1'b1;
      mem_be   = '1;
    end else if (r_state == GNT_D && w_d_req) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      if (d_wr) begin
        mem_wr = 1'b1;
        mem_be = d_be;
      end else begin
        mem_rd = 1'b1;
        mem_be = '1;
      end
    end
  end

  assign i_data        = (r_state == GNT_I) ? mem_rdata : '0;
  assign d_rdata       = (r_state == GNT_D) ? mem_rdata : '0;
  assign i_waitrequest = !((r_state == GNT_I) && !mem_waitrequest);
  assign d_waitrequest = !((r_state == GNT_D) && !mem_waitrequest);

  a_one_strobe: assert property (@(posedge clock) disable iff (!reset_n)
    !(mem_rd && mem_wr));
  a_idle_quiet: assert property (@(posedge clock) disable iff (!reset_n)
    (r_state == IDLE) |-> !(mem_rd || mem_wr));
  a_release: assert property (@(posedge clock) disable iff (!reset_n)
    w_done |=> (r_state == IDLE));

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Random and directed bench for imem_dmem_arbiter, round-robin and fixed-priority builds side by side.
module tb_imem_dmem_arbiter;

  localparam int  LIM = 8;
  localparam byte GI  = 8'h49;
  localparam byte GD  = 8'h44;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic         i_rd [2], d_rd [2], d_wr [2], mw [2];
  logic [31:0]  ia [2], da [2];
  logic [127:0] dwd [2], mrd [2];
  logic [15:0]  dbe [2];
  logic [127:0] idat [2], drd [2], mwd [2];
  logic [31:0]  ma [2];
  logic [15:0]  mbe [2];
  logic         iw [2], dw [2], mr [2], mwr [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    imem_dmem_arbiter #(
      .ADDR_WIDTH   (32),
      .DATA_WIDTH   (128),
      .FIXED_PRIO   (g),
      .STARVE_LIMIT (LIM)
    ) u_dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .i_addr          (ia[g]),
      .i_rd            (i_rd[g]),
      .i_data          (idat[g]),
      .i_waitrequest   (iw[g]),
      .d_addr          (da[g]),
      .d_rd            (d_rd[g]),
      .d_wr            (d_wr[g]),
      .d_wdata         (dwd[g]),
      .d_be            (dbe[g]),
      .d_rdata         (drd[g]),
      .d_waitrequest   (dw[g]),
      .mem_addr        (ma[g]),
      .mem_rd          (mr[g]),
      .mem_wr          (mwr[g]),
      .mem_wdata       (mwd[g]),
      .mem_be          (mbe[g]),
      .mem_rdata       (mrd[g]),
      .mem_waitrequest (mw[g])
    );
  end

  // Reference model: owner of the memory port (0 none, 1 fetch, 2 data).
  int  own [2];
  bit  lastd [2];
  int  scnt [2];
  bit  done_i [2], done_d [2];
  byte glog [2][$];
  int  n_chk = 0;
  int  n_err = 0;

  task automatic check(input string tag, input int k, input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      bit gi, gd, wr;
      gi = (own[k] == 1) && i_rd[k];
      gd = (own[k] == 2) && (d_rd[k] || d_wr[k]);
      wr = d_wr[k];
      check("mem_rd",  k, mr[k],  gi || (gd && !wr));
      check("mem_wr",  k, mwr[k], gd && wr);
      check("i_wait",  k, iw[k],  !(own[k] == 1 && !mw[k]));
      check("d_wait",  k, dw[k],  !(own[k] == 2 && !mw[k]));
      check("i_data",  k, idat[k], (own[k] == 1) ? mrd[k] : 128'd0);
      check("d_rdata", k, drd[k],  (own[k] == 2) ? mrd[k] : 128'd0);
      if (gi) begin
        check("addr_i", k, ma[k],  ia[k]);
        check("be_i",   k, mbe[k], 16'hFFFF);
      end
      if (gd) begin
        check("addr_d",  k, ma[k],  da[k]);
        check("wdata_d", k, mwd[k], dwd[k]);
        check("be_d",    k, mbe[k], wr ? dbe[k] : 16'hFFFF);
      end
      if (own[k] == 0) begin
        check("addr_idle",  k, ma[k],  32'd0);
        check("wdata_idle", k, mwd[k], 128'd0);
      end
      if (!iw[k]) glog[k].push_back(GI);
      if (!dw[k]) glog[k].push_back(GD);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit ir, dr;
      int nxt;
      ir = i_rd[k];
      dr = d_rd[k] || d_wr[k];
      done_i[k] = 1'b0;
      done_d[k] = 1'b0;
      case (own[k])
        0: begin
          if (ir && dr) begin
            if (k == 1) nxt = (scnt[k] == LIM) ? 1 : 2;
            else        nxt = lastd[k] ? 1 : 2;
          end else begin
            nxt = ir ? 1 : (dr ? 2 : 0);
          end
          if (nxt == 1) scnt[k] = 0;
          else if (nxt == 2 && ir && scnt[k] < LIM) scnt[k]++;
          own[k] = nxt;
        end
        1: if (!ir) own[k] = 0;
           else if (!mw[k]) begin own[k] = 0; lastd[k] = 1'b0; done_i[k] = 1'b1; end
        default: if (!dr) own[k] = 0;
           else if (!mw[k]) begin own[k] = 0; lastd[k] = 1'b1; done_d[k] = 1'b1; end
      endcase
    end
  endtask

  task automatic cycle();
    @(negedge clock);
    check_all();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic set_all(input logic vi, input logic vdr, input logic vdw, input logic vmw);
    for (int k = 0; k < 2; k++) begin
      i_rd[k] = vi; d_rd[k] = vdr; d_wr[k] = vdw; mw[k] = vmw;
    end
  endtask

  task automatic do_reset(input bit clear_inputs);
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_mem_rd", k, mr[k],  1'b0);
      check("rst_mem_wr", k, mwr[k], 1'b0);
      check("rst_i_wait", k, iw[k],  1'b1);
      check("rst_d_wait", k, dw[k],  1'b1);
      own[k] = 0; lastd[k] = 1'b0; scnt[k] = 0;
      done_i[k] = 1'b0; done_d[k] = 1'b0;
      glog[k].delete();
      if (clear_inputs) begin
        i_rd[k] = 0; d_rd[k] = 0; d_wr[k] = 0; mw[k] = 0;
        ia[k] = '0; da[k] = '0; dwd[k] = '0; dbe[k] = '0;
        mrd[k] = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic client();
    for (int k = 0; k < 2; k++) begin
      if (done_i[k]) i_rd[k] = 1'b0;
      if (!i_rd[k]) begin
        if ($urandom % 3 == 0) begin
          i_rd[k] = 1'b1;
          ia[k] = $urandom & 32'hFFFF_FFF0;
        end
      end else if ($urandom % 40 == 0) begin
        i_rd[k] = 1'b0;
      end
      if (done_d[k]) begin d_rd[k] = 1'b0; d_wr[k] = 1'b0; end
      if (!(d_rd[k] || d_wr[k])) begin
        case ($urandom % 8)
          0, 1, 2: d_rd[k] = 1'b1;
          3, 4, 5: d_wr[k] = 1'b1;
          6:       begin d_rd[k] = 1'b1; d_wr[k] = 1'b1; end
          default: ;
        endcase
        da[k]  = $urandom & 32'hFFFF_FFF0;
        dwd[k] = {$urandom, $urandom, $urandom, $urandom};
        dbe[k] = 16'($urandom);
      end else if ($urandom % 40 == 0) begin
        d_rd[k] = 1'b0; d_wr[k] = 1'b0;
      end
      mw[k]  = ($urandom % 3 == 0);
      mrd[k] = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  initial begin
    // Single fetch read, zero-wait memory.
    do_reset(1);
    set_all(1, 0, 0, 0);
    for (int k = 0; k < 2; k++) ia[k] = 32'h100;
    cycle();
    cycle();
    set_all(0, 0, 0, 0);
    cycle();
    for (int k = 0; k < 2; k++) begin
      check("t1_grants", k, glog[k].size(), 1);
      if (glog[k].size() > 0) check("t1_first", k, glog[k][0], GI);
    end

    // Both ports requesting continuously: alternation vs. starvation guard.
    do_reset(1);
    set_all(1, 1, 0, 0);
    for (int k = 0; k < 2; k++) begin ia[k] = 32'h1000; da[k] = 32'h2000; end
    repeat (36) cycle();
    set_all(0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      check("seq_len", k, glog[k].size(), 18);
      for (int n = 0; n < glog[k].size() && n < 18; n++)
        check("seq_grant", k, glog[k][n],
              (k == 0) ? ((n % 2) ? GI : GD) : ((n % 9 == 8) ? GI : GD));
    end

    // Stalled write with fetch pending.
    do_reset(1);
    for (int k = 0; k < 2; k++) begin
      i_rd[k] = 1; ia[k] = 32'h300;
      d_wr[k] = 1; da[k] = 32'h200; dbe[k] = 16'h00F0;
      dwd[k] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    end
    for (int n = 0; n < 5; n++) begin
      for (int k = 0; k < 2; k++) mw[k] = (n >= 1 && n <= 3);
      cycle();
    end
    for (int k = 0; k < 2; k++) begin d_wr[k] = 0; mw[k] = 0; end
    cycle();
    cycle();
    set_all(0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      check("t3_grants", k, glog[k].size(), 2);
      if (glog[k].size() == 2) begin
        check("t3_first",  k, glog[k][0], GD);
        check("t3_second", k, glog[k][1], GI);
      end
    end

    // Async reset in the middle of a stalled data write.
    do_reset(1);
    set_all(0, 0, 1, 1);
    for (int k = 0; k < 2; k++) da[k] = 32'h240;
    cycle();
    cycle();
    #2;
    do_reset(0);
    for (int k = 0; k < 2; k++) mw[k] = 0;
    cycle();
    cycle();
    set_all(0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      check("t5_grants", k, glog[k].size(), 1);
      if (glog[k].size() > 0) check("t5_first", k, glog[k][0], GD);
    end

    // Fetch drops its request mid-grant; pending data read follows.
    do_reset(1);
    set_all(1, 0, 0, 1);
    for (int k = 0; k < 2; k++) begin ia[k] = 32'h400; da[k] = 32'h500; end
    cycle();
    for (int k = 0; k < 2; k++) d_rd[k] = 1;
    cycle();
    for (int k = 0; k < 2; k++) i_rd[k] = 0;
    cycle();
    for (int k = 0; k < 2; k++) mw[k] = 0;
    cycle();
    cycle();
    set_all(0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      check("t6_grants", k, glog[k].size(), 1);
      if (glog[k].size() > 0) check("t6_first", k, glog[k][0], GD);
    end

    // Randomized traffic against the model.
    do_reset(1);
    repeat (4000) begin
      client();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
